iw_sequencer: RTL

Parametrised multi-cycle executor for wide-immediate move instructions (MOVZ, MOVK, MOVN) in the control unit. It accepts a decoded instruction strobe and sequences the register-file read and write needed to build the result. It assembles the wide immediate internally instead of relying on the ALU, and handles any data width that is a multiple of the immediate width. It sits beside the other instruction-class decoders and owns the register file ports only while `busy` is high.

---
 rtl/iw_pkg.sv | 27 ++
 rtl/iw_imm_place.sv | 34 +++
 rtl/iw_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/iw_pkg.sv
// iw_pkg: shared definitions for the wide-immediate move sequencer.
//   - opcode encodings for MOVN / MOVZ / MOVK (2'b01 is the illegal encoding)
//   - FSM state type and state encodings
//   - calc_sh_w(): width of the halfword slot index for a given slot count
package iw_pkg;

    localparam logic [1:0] OPC_MOVN = 2'b00;
    localparam logic [1:0] OPC_MOVZ = 2'b10;
    localparam logic [1:0] OPC_MOVK = 2'b11;

    // FSM state type and encodings
    typedef logic [1:0] iw_state_t;

    localparam iw_state_t ST_IDLE  = 2'd0;
    localparam iw_state_t ST_READ  = 2'd1;
    localparam iw_state_t ST_WRITE = 2'd2;
    localparam iw_state_t ST_ERR   = 2'd3;

    // Slot index needs at least one bit even when there is a single slot.
    function automatic int unsigned calc_sh_w(input int unsigned slots);
        if (slots <= 2) begin
            return 1;
        end
        return $clog2(slots);
    endfunction

endpackage

// File: rtl/iw_imm_place.sv
// iw_imm_place: places an immediate into halfword slot 'hw' of a DATA_WIDTH word.
// Ports:
//   imm    in   IMM_WIDTH   immediate value
//   hw     in   SH_W        destination slot index
//   placed out  DATA_WIDTH  imm shifted into slot hw, zeros elsewhere
//   mask   out  DATA_WIDTH  all-ones over slot hw, zeros elsewhere
// An out-of-range hw yields placed = mask = 0; the caller rejects such requests.
module iw_imm_place
    import iw_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned IMM_WIDTH  = 16,
    localparam int unsigned HW_SLOTS  = DATA_WIDTH / IMM_WIDTH,
    localparam int unsigned SH_W      = calc_sh_w(HW_SLOTS)
) (
    input  logic [IMM_WIDTH-1:0]  imm,
    input  logic [SH_W-1:0]       hw,
    output logic [DATA_WIDTH-1:0] placed,
    output logic [DATA_WIDTH-1:0] mask
);

    // Slot-select loop instead of a variable shift keeps widths exact.
    always_comb begin
        placed = '0;
        mask   = '0;
        for (int unsigned s = 0; s < HW_SLOTS; s++) begin
            if (32'(hw) == s) begin
                placed[s*IMM_WIDTH +: IMM_WIDTH] = imm;
                mask[s*IMM_WIDTH +: IMM_WIDTH]   = '1;
            end
        end
    end

endmodule

// File: rtl/iw_sequencer.sv
// iw_sequencer: multi-cycle executor for MOVZ / MOVK / MOVN.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   start               one-cycle instruction strobe (accepted only when idle)
//   opc, hw, imm, rd    instruction fields, valid with start
//   busy                high in any state other than idle
//   done, error         one-cycle completion pulse; error marks a rejected instruction
//   rf_read_addr/data   register-file port B (combinational read), used by MOVK only
//   rf_write, rf_write_addr, rf_write_data   register-file write port
module iw_sequencer
    import iw_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned IMM_WIDTH  = 16,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ZERO_REG   = 31,
    localparam int unsigned HW_SLOTS  = DATA_WIDTH / IMM_WIDTH,
    localparam int unsigned SH_W      = calc_sh_w(HW_SLOTS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            opc,
    input  logic [SH_W-1:0]       hw,
    input  logic [IMM_WIDTH-1:0]  imm,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [REG_ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    output logic                  rf_write,
    output logic [REG_ADDR_W-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data
);

    iw_state_t             state_q, state_d;
    logic [1:0]            opc_q;
    logic [SH_W-1:0]       hw_q;
    logic [IMM_WIDTH-1:0]  imm_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_WIDTH-1:0] hold_q;

    logic                  accept;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] placed;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] result;

    assign accept  = start && (state_q == ST_IDLE);
    // 2'b01 has no defined operation; a slot past the top of the word is also rejected.
    assign illegal = (opc == 2'b01) || (32'(hw) >= HW_SLOTS);

    iw_imm_place #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMM_WIDTH  (IMM_WIDTH)
    ) u_imm_place (
        .imm    (imm_q),
        .hw     (hw_q),
        .placed (placed),
        .mask   (mask)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        state_d = ST_ERR;
                    end else if (opc == OPC_MOVK) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            opc_q   <= '0;
            hw_q    <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opc_q <= opc;
                hw_q  <= hw;
                imm_q <= imm;
                rd_q  <= rd;
            end
            // Single read of rd; later register updates are deliberately not seen.
            if (state_q == ST_READ) begin
                hold_q <= rf_read_data;
            end
        end
    end

    always_comb begin
        result = '0;
        unique case (opc_q)
            OPC_MOVZ: result = placed;
            OPC_MOVN: result = ~placed;
            OPC_MOVK: result = (hold_q & ~mask) | placed;
            default:  result = '0;
        endcase
    end

    always_comb begin
        busy          = (state_q != ST_IDLE);
        done          = 1'b0;
        error         = 1'b0;
        rf_read_addr  = '0;
        rf_write      = 1'b0;
        rf_write_addr = '0;
        rf_write_data = '0;
        unique case (state_q)
            ST_READ: begin
                rf_read_addr = rd_q;
            end
            ST_WRITE: begin
                rf_write_addr = rd_q;
                rf_write_data = result;
                rf_write      = (32'(rd_q) != ZERO_REG);
                done          = 1'b1;
            end
            ST_ERR: begin
                done  = 1'b1;
                error = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
